// File: rtl/module_keypad_enc_pkg.sv
// Shared types, key table and row decode helper
// for the 4x4 matrix keypad encoder.
package pkg_keypad;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } kp_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } low_t;

    // Indexed [row][col]; letters sit in column 3, '*'=E and '#'=F.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    localparam logic [3:0] ALL_HIGH = 4'hF;

    // Reports whether exactly one bit is low, and which one.
    function automatic low_t find_low(input logic [3:0] v);
        low_t r;
        r = '0;
        case (v)
            4'b1110: r = '{hit: 1'b1, idx: 2'd0};
            4'b1101: r = '{hit: 1'b1, idx: 2'd1};
            4'b1011: r = '{hit: 1'b1, idx: 2'd2};
            4'b0111: r = '{hit: 1'b1, idx: 2'd3};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/module_keypad_enc_sync2.sv
// Two-flop synchroniser for asynchronous inputs,
// resetting to the idle (all-high) level.
module module_sync2 #(
    parameter int            W       = 4,
    parameter logic [W-1:0]  RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/module_keypad_enc.sv
// 4x4 active-low keypad scanner with press/release
// debounce and 4-bit key encoding.
module module_keypad_enc
    import pkg_keypad::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic [3:0]       rs;
    kp_state_t        state;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ring;
    logic [3:0]       pat;
    logic [1:0]       row;
    logic [1:0]       col;
    logic [3:0]       code;
    logic             valid;
    logic             held;

    low_t             row_hit;
    low_t             col_hit;
    logic [3:0]       ring_next;

    module_sync2 #(
        .W       (4),
        .RST_VAL (ALL_HIGH)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_i),
        .q     (rs)
    );

    assign row_hit   = find_low(rs);
    assign col_hit   = find_low(ring);
    assign ring_next = {ring[2:0], ring[3]};

    // The ring only moves in SCAN; DEBOUNCE and PRESSED hold it
    // so the latched column stays driven.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCAN;
            div   <= '0;
            cnt   <= '0;
            ring  <= 4'b1110;
            pat   <= ALL_HIGH;
            row   <= '0;
            col   <= '0;
            code  <= 4'h0;
            valid <= 1'b0;
            held  <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (row_hit.hit) begin
                            row   <= row_hit.idx;
                            col   <= col_hit.idx;
                            pat   <= rs;
                            cnt   <= '0;
                            state <= DEBOUNCE;
                        end else begin
                            ring <= ring_next;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (rs == pat) begin
                        if (cnt == CNT_LAST) begin
                            code  <= KEY_MAP[row][col];
                            valid <= 1'b1;
                            held  <= 1'b1;
                            cnt   <= '0;
                            state <= PRESSED;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        ring  <= ring_next;
                        div   <= '0;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                PRESSED: begin
                    // Counts only all-high cycles; any low row restarts it.
                    if (rs == ALL_HIGH) begin
                        if (cnt == CNT_LAST) begin
                            held  <= 1'b0;
                            cnt   <= '0;
                            ring  <= ring_next;
                            div   <= '0;
                            state <= SCAN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

    assign col_o       = ring;
    assign key_code_o  = code;
    assign key_valid_o = valid;
    assign key_held_o  = held;

endmodule

// File: tb/tb_module_keypad_enc.sv
// Randomised and directed bench for module_keypad_enc
// against a cycle-level behavioural keypad model.
module tb_module_keypad_enc;

    localparam int SD = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_i = 4'hF;
    logic [3:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_held_o;

    module_keypad_enc #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int ticks    = 0;

    // keys[r][c] = 1 while that switch is closed
    logic [3:0] keys [4];

    int unsigned kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                               7, 8, 9, 12, 14, 0, 15, 13};

    // model: mode 0 scanning, 1 settling, 2 key down
    int         m_mode, m_col, m_dwell, m_stable, m_row, m_kcol;
    logic [3:0] m_code;
    bit         m_valid, m_held;
    logic [3:0] sy0, sy1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] rows_for(input logic [3:0] col);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ~|(keys[i] & ~col);
        return r;
    endfunction

    function automatic int single_low(input logic [3:0] v);
        int n, k;
        n = 0;
        k = -1;
        for (int i = 0; i < 4; i++)
            if (!v[i]) begin
                n++;
                k = i;
            end
        return (n == 1) ? k : -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_col = 0; m_dwell = 0; m_stable = 0;
        m_row = 0; m_kcol = 0; m_code = 4'h0;
        m_valid = 0; m_held = 0; sy0 = 4'hF; sy1 = 4'hF;
    endtask

    task automatic model_step(input logic [3:0] r, input bit rst);
        logic [3:0] rs;
        int k;
        if (!rst) begin
            model_reset();
            return;
        end
        rs = sy1;
        sy1 = sy0;
        sy0 = r;
        m_valid = 0;
        if (m_mode == 0) begin
            m_dwell++;
            if (m_dwell == SD) begin
                m_dwell = 0;
                k = single_low(rs);
                if (k >= 0) begin
                    m_row = k; m_kcol = m_col; m_stable = 0; m_mode = 1;
                end else m_col = (m_col + 1) % 4;
            end
        end else if (m_mode == 1) begin
            if (single_low(rs) == m_row) begin
                m_stable++;
                if (m_stable == DC) begin
                    m_code = 4'(kmap[m_row * 4 + m_kcol]);
                    m_valid = 1; m_held = 1; m_mode = 2; m_stable = 0;
                end
            end else begin
                m_mode = 0; m_col = (m_col + 1) % 4; m_dwell = 0;
            end
        end else begin
            if (rs == 4'hF) begin
                m_stable++;
                if (m_stable == DC) begin
                    m_held = 0; m_mode = 0; m_stable = 0;
                    m_col = (m_col + 1) % 4; m_dwell = 0;
                end
            end else m_stable = 0;
        end
    endtask

    task automatic tick();
        logic [3:0] rsamp;
        bit rsts;
        @(negedge clk);
        row_i = rows_for(col_o);
        rsamp = row_i;
        rsts = rst_n;
        @(posedge clk);
        #1;
        ticks++;
        model_step(rsamp, rsts);
        if (key_valid_o === 1'b1) pulses++;
        chk("col", col_o, 4'hF ^ (4'b1 << m_col));
        chk("valid", key_valid_o, m_valid);
        chk("held", key_held_o, m_held);
        chk("code", key_code_o, m_code);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pulse(input string tag, input int bound);
        int p0, i;
        p0 = pulses;
        i = 0;
        while (pulses == p0 && i < bound) begin
            tick();
            i++;
        end
        chk(tag, pulses - p0, 1);
    endtask

    task automatic clear_keys();
        for (int i = 0; i < 4; i++) keys[i] = 4'h0;
    endtask

    task automatic random_episode();
        int r, c, b, h;
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        b = $urandom_range(0, 4);
        for (int i = 0; i < b; i++) begin
            keys[r][c] = ~keys[r][c];
            run($urandom_range(1, 3));
        end
        keys[r][c] = 1'b1;
        if ($urandom_range(0, 3) == 0)
            keys[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
        h = $urandom_range(10, 90);
        run(h);
        b = $urandom_range(0, 3);
        for (int i = 0; i < b; i++) begin
            keys[r][c] = ~keys[r][c];
            run($urandom_range(1, 2));
        end
        clear_keys();
        run($urandom_range(12, 40));
    endtask

    int gaps;
    int t0;

    initial begin
        clear_keys();
        model_reset();
        rst_n = 1'b0;
        #23;
        chk("rst_col", col_o, 4'b1110);
        chk("rst_code", key_code_o, 4'h0);
        chk("rst_valid", key_valid_o, 1'b0);
        chk("rst_held", key_held_o, 1'b0);
        run(2);
        rst_n = 1'b1;

        pulses = 0;
        run(40);
        chk("idle_pulses", pulses, 0);

        keys[1][1] = 1'b1;
        wait_pulse("r1c1_pulse", 100);
        chk("r1c1_code", key_code_o, 4'h5);
        run(20);
        chk("r1c1_held", key_held_o, 1'b1);
        clear_keys();
        run(10);
        chk("r1c1_release", key_held_o, 1'b0);
        run(10);

        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            keys[3][1] = 1'b1;
            tick();
            keys[3][1] = 1'b0;
            tick();
        end
        keys[3][1] = 1'b1;
        run(60);
        chk("r3c1_pulses", pulses, 1);
        chk("r3c1_code", key_code_o, 4'h0);
        clear_keys();
        run(20);

        pulses = 0;
        keys[0][3] = 1'b1;
        gaps = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pulses > 0 && key_held_o !== 1'b1) gaps++;
        end
        chk("r0c3_pulses", pulses, 1);
        chk("r0c3_code", key_code_o, 4'hA);
        chk("r0c3_gaps", gaps, 0);
        clear_keys();
        run(20);

        pulses = 0;
        keys[0][0] = 1'b1;
        keys[2][0] = 1'b1;
        run(50);
        chk("dual_pulses", pulses, 0);
        keys[2][0] = 1'b0;
        run(60);
        chk("dual_rel_pulses", pulses, 1);
        chk("dual_code", key_code_o, 4'h1);
        clear_keys();
        run(20);

        pulses = 0;
        keys[1][2] = 1'b1;
        for (int i = 0; i < 300 && !(m_mode == 1 && m_stable == 5); i++)
            tick();
        chk("deb_reached", (m_mode == 1 && m_stable == 5), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_col", col_o, 4'b1110);
        chk("arst_code", key_code_o, 4'h0);
        chk("arst_valid", key_valid_o, 1'b0);
        chk("arst_held", key_held_o, 1'b0);
        run(2);
        chk("arst_pulses", pulses, 0);
        rst_n = 1'b1;
        t0 = ticks;
        wait_pulse("rekey_pulse", 100);
        chk("rekey_latency", ticks - t0, 20);
        chk("rekey_code", key_code_o, 4'h6);
        clear_keys();
        run(20);

        for (int e = 0; e < 30; e++) random_episode();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
